// File: rtl/xorshift32_stream.sv
// ----------------------------------------------------------------------------
// xorshift32_stream
//
// Multi-lane xorshift32 random-vector generator. A start request launches a
// burst of `count` vectors; every vector carries NUM_OUTPUTS lane values of
// OUT_WIDTH bits, optionally scaled into [0, range-1]. Vectors leave on a
// valid/ready stream so the consumer can stall the generator at any time.
//
// Ports:
//   clk        - clock, all logic on the rising edge
//   rst        - synchronous active-high reset
//   start      - begin a burst (only honoured while idle)
//   stop       - abort the current burst, no done pulse
//   seed       - base seed, sampled with start
//   count      - number of vectors in the burst, sampled with start
//   range      - output bound, 0 selects the top OUT_WIDTH state bits
//   busy       - high from LOAD until the return to IDLE
//   out_valid  - out_random holds a vector
//   out_ready  - consumer accepts the current vector
//   out_random - lane values, index = lane
//   done       - one-cycle pulse when a burst completes normally
// ----------------------------------------------------------------------------
module xorshift32_stream #(
    parameter int NUM_OUTPUTS = 4,
    parameter int OUT_WIDTH   = 32,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   stop,
    input  logic [31:0]            seed,
    input  logic [COUNT_WIDTH-1:0] count,
    input  logic [OUT_WIDTH-1:0]   range,
    output logic                   busy,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_WIDTH-1:0]   out_random [NUM_OUTPUTS],
    output logic                   done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    // Substitute for an all-zero lane seed, which would lock xorshift at 0
    localparam logic [31:0] ZERO_SEED_SUB = 32'h6D2B79F5;

    logic [1:0]             r_state;
    logic [31:0]            r_laneState [NUM_OUTPUTS];
    logic [OUT_WIDTH-1:0]   r_outRandom [NUM_OUTPUTS];
    logic [COUNT_WIDTH-1:0] r_remaining;
    logic                   r_busy;
    logic                   r_outValid;
    logic                   r_done;

    logic [31:0]            w_laneSeed  [NUM_OUTPUTS];
    logic [31:0]            w_nextState [NUM_OUTPUTS];
    logic [OUT_WIDTH-1:0]   w_scaled    [NUM_OUTPUTS];

    // One xorshift32 step with the 13/17/5 shift triple
    function automatic logic [31:0] xsStep(input logic [31:0] x);
        logic [31:0] y;
        y = x;
        y = y ^ (y << 13);
        y = y ^ (y >> 17);
        y = y ^ (y << 5);
        return y;
    endfunction

    // Map a 32-bit state into the output range. A nonzero bound uses the
    // high half of s * range, which lands in [0, range-1] without a divider.
    function automatic logic [OUT_WIDTH-1:0] scaleState(
        input logic [31:0]          s,
        input logic [OUT_WIDTH-1:0] rng
    );
        logic [31+OUT_WIDTH:0] prod;
        prod = {{OUT_WIDTH{1'b0}}, s} * {32'd0, rng};
        if (rng == '0) begin
            return s[31 -: OUT_WIDTH];
        end
        return prod[31+OUT_WIDTH:32];
    endfunction

    // Per-lane seed derivation, next-state and scaled value. Each lane mixes
    // the base seed with a golden-ratio multiple of its index so lanes
    // start from decorrelated states.
    for (genvar g = 0; g < NUM_OUTPUTS; g++) begin : g_lane
        localparam logic [31:0] LANE_MIX = 32'(g) * 32'h9E3779B9;
        logic [31:0] w_mixed;

        assign w_mixed        = seed ^ LANE_MIX;
        assign w_laneSeed[g]  = (w_mixed == 32'd0) ? ZERO_SEED_SUB : w_mixed;
        assign w_nextState[g] = xsStep(r_laneState[g]);
        assign w_scaled[g]    = scaleState(w_nextState[g], range);
    end

    // Burst control. stop outranks the handshake in LOAD and RUN and leaves
    // the lane states where they are. A vector is produced on the LOAD edge
    // and on every accepted handshake while vectors remain; the handshake
    // that retires the last vector drops out_valid and pulses done together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_outValid  <= 1'b0;
            r_done      <= 1'b0;
            r_remaining <= '0;
            for (int i = 0; i < NUM_OUTPUTS; i++) begin
                r_laneState[i] <= 32'd0;
                r_outRandom[i] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state     <= ST_LOAD;
                        r_busy      <= 1'b1;
                        r_remaining <= count;
                        for (int i = 0; i < NUM_OUTPUTS; i++) begin
                            r_laneState[i] <= w_laneSeed[i];
                        end
                    end
                end
                ST_LOAD: begin
                    if (stop) begin
                        r_state    <= ST_IDLE;
                        r_busy     <= 1'b0;
                        r_outValid <= 1'b0;
                    end else if (r_remaining == '0) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state     <= ST_RUN;
                        r_outValid  <= 1'b1;
                        r_remaining <= r_remaining - 1'b1;
                        for (int i = 0; i < NUM_OUTPUTS; i++) begin
                            r_laneState[i] <= w_nextState[i];
                            r_outRandom[i] <= w_scaled[i];
                        end
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        r_state    <= ST_IDLE;
                        r_busy     <= 1'b0;
                        r_outValid <= 1'b0;
                    end else if (r_outValid && out_ready) begin
                        if (r_remaining != '0) begin
                            r_remaining <= r_remaining - 1'b1;
                            for (int i = 0; i < NUM_OUTPUTS; i++) begin
                                r_laneState[i] <= w_nextState[i];
                                r_outRandom[i] <= w_scaled[i];
                            end
                        end else begin
                            r_state    <= ST_IDLE;
                            r_busy     <= 1'b0;
                            r_outValid <= 1'b0;
                            r_done     <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_busy     <= 1'b0;
                    r_outValid <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign out_valid  = r_outValid;
    assign done       = r_done;
    assign out_random = r_outRandom;

endmodule

// File: tb/tb_xorshift32_stream.sv
// ----------------------------------------------------------------------------
// tb_xorshift32_stream
//
// Drives two generator instances from the same control stream: a default
// 32-bit-lane instance and an 8-bit-lane instance. Every observed vector is
// compared with a reference that walks each lane's xorshift sequence from
// its derived seed and scales it with plain 64-bit arithmetic.
// ----------------------------------------------------------------------------
module tb_xorshift32_stream;

    localparam int LANES = 4;
    localparam int CW    = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          stop;
    logic          outReady;
    logic [31:0]   seed;
    logic [CW-1:0] count;
    logic [31:0]   rangeWide;
    logic [7:0]    rangeNarrow;

    logic          busyWide, validWide, doneWide;
    logic [31:0]   randWide [LANES];
    logic          busyNarrow, validNarrow, doneNarrow;
    logic [7:0]    randNarrow [LANES];

    int            checks   = 0;
    int            failures = 0;

    logic [31:0]   model     [LANES];
    logic [31:0]   expWide   [LANES];
    logic [31:0]   expNarrow [LANES];
    logic [31:0]   firstVec  [LANES];
    logic [31:0]   acceptedLog [$];
    logic [31:0]   refLog      [$];

    always #5 clk = ~clk;

    xorshift32_stream #(.NUM_OUTPUTS(LANES), .OUT_WIDTH(32), .COUNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .seed(seed),
        .count(count), .range(rangeWide), .busy(busyWide), .out_valid(validWide),
        .out_ready(outReady), .out_random(randWide), .done(doneWide)
    );

    xorshift32_stream #(.NUM_OUTPUTS(LANES), .OUT_WIDTH(8), .COUNT_WIDTH(CW)) dutNarrow (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .seed(seed),
        .count(count), .range(rangeNarrow), .busy(busyNarrow), .out_valid(validNarrow),
        .out_ready(outReady), .out_random(randNarrow), .done(doneNarrow)
    );

    // Reference xorshift32 step
    function automatic logic [31:0] xsStep(input logic [31:0] x);
        logic [31:0] y;
        y = x;
        y = y ^ (y << 13);
        y = y ^ (y >> 17);
        y = y ^ (y << 5);
        return y;
    endfunction

    // Reference lane seed derivation
    function automatic logic [31:0] laneSeedModel(input logic [31:0] s, input int lane);
        logic [31:0] v;
        v = s ^ (32'(lane) * 32'h9E3779B9);
        return (v == 32'd0) ? 32'h6D2B79F5 : v;
    endfunction

    // Reference scaling: top bits for range 0, otherwise floor(s*range/2^32)
    function automatic logic [31:0] scaleModel(input logic [31:0] s, input logic [31:0] rng,
                                               input int width);
        longint unsigned p;
        if (rng == 32'd0) return s >> (32 - width);
        p = longint'(s) * longint'(rng);
        return 32'(p >> 32);
    endfunction

    // Single comparison point: counts and reports
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Advance the reference by one vector using the ranges currently applied
    task automatic advanceModel();
        for (int i = 0; i < LANES; i++) begin
            model[i]     = xsStep(model[i]);
            expWide[i]   = scaleModel(model[i], rangeWide, 32);
            expNarrow[i] = scaleModel(model[i], {24'd0, rangeNarrow}, 8);
        end
    endtask

    task automatic compareVector();
        for (int i = 0; i < LANES; i++) begin
            checkOutput($sformatf("wideLane%0d", i), randWide[i], expWide[i]);
            checkOutput($sformatf("narrowLane%0d", i), {24'd0, randNarrow[i]}, expNarrow[i]);
            if (rangeNarrow != 8'd0)
                checkOutput($sformatf("narrowBound%0d", i),
                            32'(randNarrow[i] < rangeNarrow), 32'd1);
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "Busy"}, {30'd0, busyWide, busyNarrow}, 32'd0);
        checkOutput({tag, "Valid"}, {30'd0, validWide, validNarrow}, 32'd0);
        checkOutput({tag, "Done"}, {30'd0, doneWide, doneNarrow}, 32'd0);
    endtask

    // Run one burst. readyMode: 0 = always ready, 1 = pattern 1,0,0,
    // 2 = random. stopAt / startMidAt name a 1-based valid cycle, -1 = never.
    task automatic applyStimulus(input logic [31:0] s, input int cnt,
                                 input logic [31:0] rw, input logic [7:0] rn,
                                 input int readyMode, input int stopAt,
                                 input int startMidAt);
        int  accepted    = 0;
        int  validCycles = 0;
        int  budget;
        bit  finished    = 1'b0;
        bit  r;
        acceptedLog.delete();
        @(negedge clk);
        seed        = s;
        count       = CW'(cnt);
        rangeWide   = rw;
        rangeNarrow = rn;
        outReady    = 1'b1;
        start       = 1'b1;
        for (int i = 0; i < LANES; i++) model[i] = laneSeedModel(s, i);
        @(negedge clk);
        start = 1'b0;
        checkOutput("busyAfterStart", {30'd0, busyWide, busyNarrow}, 32'd3);
        checkOutput("validInLoad", {30'd0, validWide, validNarrow}, 32'd0);
        if (cnt == 0) begin
            @(negedge clk);
            checkOutput("zeroCountDone", {30'd0, doneWide, doneNarrow}, 32'd3);
            checkOutput("zeroCountBusy", {30'd0, busyWide, busyNarrow}, 32'd0);
            checkOutput("zeroCountValid", {30'd0, validWide, validNarrow}, 32'd0);
            @(negedge clk);
            checkIdleOutputs("zeroCountAfter");
            return;
        end
        advanceModel();
        budget = cnt * 4 + 20;
        while (!finished && budget > 0) begin
            @(negedge clk);
            budget--;
            checkOutput("validHigh", {30'd0, validWide, validNarrow}, 32'd3);
            checkOutput("busyHigh", {30'd0, busyWide, busyNarrow}, 32'd3);
            checkOutput("doneLow", {30'd0, doneWide, doneNarrow}, 32'd0);
            compareVector();
            validCycles++;
            if (validCycles == 1)
                for (int i = 0; i < LANES; i++) firstVec[i] = randWide[i];
            if (validCycles == startMidAt) begin
                start = 1'b1;
                seed  = ~s;
            end else begin
                start = 1'b0;
            end
            if (validCycles == stopAt) begin
                stop = 1'b1;
                @(negedge clk);
                stop  = 1'b0;
                start = 1'b0;
                checkIdleOutputs("afterStop");
                @(negedge clk);
                checkIdleOutputs("stopSettled");
                return;
            end
            case (readyMode)
                0:       r = 1'b1;
                1:       r = ((validCycles - 1) % 3) == 0;
                default: r = 1'($urandom_range(0, 1));
            endcase
            outReady = r;
            if (r) begin
                acceptedLog.push_back(randWide[0]);
                accepted++;
                if (accepted == cnt) begin
                    @(negedge clk);
                    start    = 1'b0;
                    outReady = 1'b1;
                    finished = 1'b1;
                    checkOutput("lastValidLow", {30'd0, validWide, validNarrow}, 32'd0);
                    checkOutput("lastDone", {30'd0, doneWide, doneNarrow}, 32'd3);
                    checkOutput("lastBusyLow", {30'd0, busyWide, busyNarrow}, 32'd0);
                    @(negedge clk);
                    checkIdleOutputs("afterDone");
                end else begin
                    advanceModel();
                end
            end
        end
        if (!finished) checkOutput("burstTimeout", 32'd0, 32'd1);
        checkOutput("handshakes", 32'(accepted), 32'(cnt));
    endtask

    // Watchdog so a wedged design still ends the run
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] s;
        rst         = 1'b1;
        start       = 1'b0;
        stop        = 1'b0;
        outReady    = 1'b1;
        seed        = 32'd0;
        count       = '0;
        rangeWide   = 32'd0;
        rangeNarrow = 8'd0;
        repeat (3) @(negedge clk);
        checkIdleOutputs("reset");
        for (int i = 0; i < LANES; i++) begin
            checkOutput("resetWideLane", randWide[i], 32'd0);
            checkOutput("resetNarrowLane", {24'd0, randNarrow[i]}, 32'd0);
        end
        rst = 1'b0;

        // Single vector from seed 1
        applyStimulus(32'd1, 1, 32'd0, 8'd0, 0, -1, -1);
        checkOutput("seed1Lane0", firstVec[0], 32'h00042021);
        checkOutput("seed1Count", 32'(acceptedLog.size()), 32'd1);

        // Zero seed substitution on lane 0, long random-ready burst
        applyStimulus(32'd0, 100, 32'd0, 8'd0, 2, -1, -1);
        checkOutput("zeroSeedLane0", firstVec[0], xsStep(32'h6D2B79F5));
        checkOutput("zeroSeedLane1", firstVec[1], xsStep(32'h9E3779B9));

        // Backpressure gives the same sequence as an unstalled burst
        s = $urandom();
        applyStimulus(s, 5, 32'd0, 8'd0, 0, -1, -1);
        refLog = acceptedLog;
        applyStimulus(s, 5, 32'd0, 8'd0, 1, -1, -1);
        checkOutput("bpCount", 32'(acceptedLog.size()), 32'd5);
        for (int i = 0; i < 5 && i < acceptedLog.size(); i++)
            checkOutput($sformatf("bpSeq%0d", i), acceptedLog[i], refLog[i]);

        // Range scaling: narrow lanes bounded to 10, wide lanes random bound
        applyStimulus($urandom(), 1000, $urandom() | 32'd1, 8'd10, 2, -1, -1);

        // Zero-length burst
        applyStimulus($urandom(), 0, 32'd0, 8'd0, 0, -1, -1);

        // start during a burst is ignored
        applyStimulus($urandom(), 20, $urandom(), 8'($urandom_range(0, 255)), 0, -1, 4);

        // stop on the third valid cycle
        applyStimulus($urandom(), 10, 32'd0, 8'd0, 0, 3, -1);

        // Normal burst after an abort
        applyStimulus($urandom(), 4, 32'd0, 8'd0, 2, -1, -1);

        // Reset mid-burst, then reproduce the first burst of that seed
        s = $urandom();
        applyStimulus(s, 10, 32'd0, 8'd0, 0, -1, -1);
        refLog = acceptedLog;
        @(negedge clk);
        seed  = s;
        count = CW'(10);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkIdleOutputs("midReset");
        for (int i = 0; i < LANES; i++) begin
            checkOutput("midResetWide", randWide[i], 32'd0);
            checkOutput("midResetNarrow", {24'd0, randNarrow[i]}, 32'd0);
        end
        rst = 1'b0;
        applyStimulus(s, 10, 32'd0, 8'd0, 0, -1, -1);
        checkOutput("replayCount", 32'(acceptedLog.size()), 32'd10);
        for (int i = 0; i < 10 && i < acceptedLog.size(); i++)
            checkOutput($sformatf("replaySeq%0d", i), acceptedLog[i], refLog[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
